// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into 32-bit words
// and writes them to consecutive word indices, holding the CPU in reset until done.
module imem_loader #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DEPTH_LOG2:0]   len_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [31:0]           mem_byte_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic                  err,
    output logic [DEPTH_LOG2:0]   words_written
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [DEPTH_LOG2:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]          state;
    logic [DEPTH_LOG2:0] len_q;
    logic [DEPTH_LOG2:0] word_cnt;
    logic [DEPTH_LOG2:0] word_cnt_inc;
    logic [1:0]          byte_cnt;
    logic [31:0]         pack;
    logic [31:0]         pack_next;
    logic                accept;
    logic                len_ok;

    assign accept       = in_valid && in_ready;
    assign len_ok       = (len_words != '0) && (len_words <= MAX_LEN);
    assign word_cnt_inc = word_cnt + 1'b1;
    assign pack_next    = BIG_ENDIAN ? {pack[23:0], in_data} : {in_data, pack[31:8]};
    assign mem_byte_addr = BASE_ADDR + {{(30 - DEPTH_LOG2){1'b0}}, mem_addr, 2'b00};

    // Pack register is pure data: no reset, a discarded partial word is harmless.
    always_ff @(posedge clk) begin
        if (state == S_RECV && accept) begin
            pack <= pack_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            len_q         <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_hold      <= 1'b1;
            err           <= 1'b0;
            words_written <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q         <= len_words;
                            word_cnt      <= '0;
                            byte_cnt      <= '0;
                            words_written <= '0;
                            state         <= S_RECV;
                            in_ready      <= 1'b1;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            cpu_hold      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            // Drop ready at the same edge so no byte lands during the write cycle.
                            state     <= S_WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[DEPTH_LOG2-1:0];
                            mem_wdata <= pack_next;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we        <= 1'b0;
                    word_cnt      <= word_cnt_inc;
                    words_written <= words_written + 1'b1;
                    byte_cnt      <= '0;
                    if (word_cnt_inc == len_q) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= S_RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a word-level scoreboard of expected writes
// checked on every cycle, plus literal expectations for the key vectors.
module tb_imem_loader;

    localparam int          DL   = 12;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DL:0]   len_words = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;

    logic          in_ready, mem_we, busy, done, cpu_hold, err;
    logic [DL-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_byte_addr;
    logic [DL:0]   words_written;

    logic          in_ready_le, we_le, busy_le, done_le, hold_le, err_le;
    logic [DL-1:0] addr_le;
    logic [31:0]   wdata_le, baddr_le;
    logic [DL:0]   ww_le;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;

    typedef struct {
        int          addr;
        logic [31:0] be;
        logic [31:0] le;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur;
    logic [7:0] fixed_bytes[$];

    imem_loader #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .len_words(len_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_addr(mem_byte_addr), .busy(busy), .done(done),
        .cpu_hold(cpu_hold), .err(err), .words_written(words_written)
    );

    imem_loader #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .start(start), .len_words(len_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_le),
        .mem_we(we_le), .mem_addr(addr_le), .mem_wdata(wdata_le),
        .mem_byte_addr(baddr_le), .busy(busy_le), .done(done_le),
        .cpu_hold(hold_le), .err(err_le), .words_written(ww_le)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected word.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cpu_hold_is_not_done", {63'd0, cpu_hold}, {63'd0, !done});
            chk("le_timing_matches", {busy_le, done_le, hold_le, we_le, in_ready_le, err_le},
                {busy, done, cpu_hold, mem_we, in_ready, err});
            if (mem_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0d data %h, no write expected", mem_addr, mem_wdata);
                end else begin
                    cur = exp_q.pop_front();
                    chk("write_addr", 64'(mem_addr), 64'(cur.addr));
                    chk("write_byte_addr", 64'(mem_byte_addr), 64'(BASE + 32'(cur.addr) * 4));
                    chk("write_data_be", 64'(mem_wdata), 64'(cur.be));
                    chk("write_data_le", 64'(wdata_le), 64'(cur.le));
                    chk("write_addr_le", 64'(addr_le), 64'(cur.addr));
                    chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] pat(input int w, input int k);
        return 8'(w * 7 + k * 49 + 90);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        logic ok;
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            ok = in_ready;
            tick();
            if (ok) break;
            t++;
            if (t > 200) begin
                chk("byte_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int len, input bit ok);
        logic prev_done;
        prev_done = done;
        start = 1'b1;
        len_words = (DL+1)'(len);
        tick();
        start = 1'b0;
        if (ok) begin
            chk("start_busy", {63'd0, busy}, 64'd1);
            chk("start_hold", {63'd0, cpu_hold}, 64'd1);
            chk("start_done", {63'd0, done}, 64'd0);
            chk("start_ww_clear", 64'(words_written), 64'd0);
            chk("start_ready", {63'd0, in_ready}, 64'd1);
            chk("start_no_err", {63'd0, err}, 64'd0);
        end else begin
            chk("bad_len_err", {63'd0, err}, 64'd1);
            chk("bad_len_busy", {63'd0, busy}, 64'd0);
            chk("bad_len_done", {63'd0, done}, {63'd0, prev_done});
            chk("bad_len_hold", {63'd0, cpu_hold}, {63'd0, !prev_done});
            tick();
            chk("err_one_cycle", {63'd0, err}, 64'd0);
        end
    endtask

    task automatic pick_word(input int w, output logic [7:0] b[4]);
        for (int k = 0; k < 4; k++) begin
            if (fixed_bytes.size() > 0) b[k] = fixed_bytes.pop_front();
            else b[k] = pat(w, k);
        end
        exp_q.push_back('{addr: w, be: {b[0], b[1], b[2], b[3]}, le: {b[3], b[2], b[1], b[0]}});
    endtask

    task automatic run_load(input int len, input int gapmax, input bit poke_start);
        logic [7:0] b[4];
        int we0;
        do_start(len, 1'b1);
        we0 = we_cnt;
        for (int w = 0; w < len; w++) begin
            pick_word(w, b);
            for (int k = 0; k < 4; k++) begin
                send_byte(b[k], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
                if (k == 3) chk("we_latency", {63'd0, mem_we}, 64'd1);
                if (poke_start && k == 1) begin
                    start = 1'b1;
                    len_words = (w == 0) ? '0 : (DL+1)'(5);
                    tick();
                    start = 1'b0;
                    chk("start_ignored_err", {63'd0, err}, 64'd0);
                    chk("start_ignored_busy", {63'd0, busy}, 64'd1);
                end
            end
        end
        tick();
        chk("load_done", {63'd0, done}, 64'd1);
        chk("load_hold_released", {63'd0, cpu_hold}, 64'd0);
        chk("load_busy_low", {63'd0, busy}, 64'd0);
        chk("load_words_written", 64'(words_written), 64'(len));
        chk("load_write_count", 64'(we_cnt - we0), 64'(len));
    endtask

    initial begin
        logic [7:0] b[4];
        int we0;

        #1 reset = 1'b1;
        #3;
        chk("rst_state", {in_ready, mem_we, busy, done, cpu_hold, err}, 6'b000010);
        chk("rst_addr_data", {20'd0, mem_addr, mem_wdata}, 64'd0);
        chk("rst_ww", 64'(words_written), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Invalid lengths from IDLE
        we0 = we_cnt;
        do_start(0, 1'b0);
        do_start(4097, 1'b0);
        chk("idle_invalid_no_we", 64'(we_cnt - we0), 64'd0);

        // Single word, big-endian literal
        fixed_bytes = '{8'h3C, 8'h08, 8'h00, 8'h01};
        run_load(1, 0, 1'b0);
        chk("t1_wdata", 64'(mem_wdata), 64'h3C080001);
        chk("t1_addr", 64'(mem_addr), 64'd0);
        chk("t1_byte_addr", 64'(mem_byte_addr), 64'h00003000);
        chk("t1_le_wdata", 64'(wdata_le), 64'h0100083C);

        // Three words with random gaps, from DONE
        run_load(3, 4, 1'b0);
        chk("t2_last_addr", 64'(mem_addr), 64'd2);
        chk("t2_last_byte_addr", 64'(mem_byte_addr), 64'h00003008);

        // Restart from DONE with start pulses during RECV
        run_load(2, 2, 1'b1);

        // Invalid start from DONE keeps DONE
        do_start(0, 1'b0);
        chk("done_invalid_still_done", {63'd0, done}, 64'd1);

        // Little-endian literal
        fixed_bytes = '{8'h01, 8'h00, 8'h08, 8'h3C};
        run_load(1, 1, 1'b0);
        chk("t5_le_wdata", 64'(wdata_le), 64'h3C080001);
        chk("t5_be_wdata", 64'(mem_wdata), 64'h0100083C);

        // Reset after 6 bytes of a 2-word load
        do_start(2, 1'b1);
        pick_word(0, b);
        for (int k = 0; k < 4; k++) send_byte(b[k], 1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", {in_ready, mem_we, busy, done, cpu_hold, err}, 6'b000010);
        chk("mid_rst_addr_data", {20'd0, mem_addr, mem_wdata}, 64'd0);
        chk("mid_rst_ww", 64'(words_written), 64'd0);
        chk("mid_rst_pending", 64'(exp_q.size()), 64'd0);
        #2 reset = 1'b0;
        tick();
        run_load(1, 0, 1'b0);
        chk("after_rst_addr", 64'(mem_addr), 64'd0);

        // Full depth: last word lands at index 4095
        run_load(4096, 0, 1'b0);
        chk("full_last_addr", 64'(mem_addr), 64'd4095);
        chk("full_last_byte_addr", 64'(mem_byte_addr), 64'h00006FFC);

        tick();
        chk("no_pending_writes", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
